// File: rtl/fifo_stream_reader.sv
// Drains a non-showahead FIFO read port into a valid/ready stream with fixed-length
// packet framing, hiding the FIFO read latency behind a small skid buffer.
`timescale 1ns/1ps
module fifo_stream_reader #(
  parameter int DWIDTH     = 64,
  parameter int RD_LATENCY = 1,
  parameter int PKT_LEN    = 16
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              enable_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              src_sop_o,
  output logic              src_eop_o,
  output logic              pkt_done_o
);

  localparam int D  = RD_LATENCY + 2;
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(D - 1);
  localparam logic [CW:0]   DEPTH     = (CW + 1)'(D);
  localparam logic [15:0]   LAST_WORD = 16'(PKT_LEN - 1);

  logic [DWIDTH-1:0]   buf_mem [D];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       occ;
  logic [CW-1:0]       infl;
  logic [CW:0]         pending;
  logic [RD_LATENCY-1:0] issued;
  logic [RD_LATENCY:0]   issued_shift;
  logic [15:0]         wcnt;
  logic                push;
  logic                pop;
  logic                valid;
  logic                last_word;

  // Words already requested but not yet landed count against buffer space.
  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      infl = infl + CW'(issued[i]);
    end
  end

  assign pending      = {1'b0, occ} + {1'b0, infl};
  assign fifo_rdreq_o = enable_i && !fifo_empty_i && (pending < DEPTH);
  assign issued_shift = {issued, fifo_rdreq_o};
  assign push         = issued[RD_LATENCY-1];
  assign valid        = (occ != '0);
  assign pop          = valid && src_ready_i;
  assign last_word    = (wcnt == LAST_WORD);

  assign src_valid_o = valid;
  assign src_data_o  = valid ? buf_mem[head] : '0;
  assign src_sop_o   = valid && (wcnt == 16'd0);
  assign src_eop_o   = valid && last_word;

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_mem[tail] <= fifo_q_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      head       <= '0;
      tail       <= '0;
      occ        <= '0;
      issued     <= '0;
      wcnt       <= '0;
      pkt_done_o <= 1'b0;
    end else begin
      issued <= issued_shift[RD_LATENCY-1:0];
      if (push) begin
        tail <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
      end
      if (pop) begin
        head <= (head == LAST_PTR) ? '0 : head + 1'b1;
        wcnt <= last_word ? 16'd0 : wcnt + 16'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      pkt_done_o <= pop && last_word;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and randomized bench for fifo_stream_reader against a queue-based model
// of the FIFO and of the expected packetized stream.
`timescale 1ns/1ps
module tb_fifo_stream_reader;

  localparam int DW   = 16;
  localparam int LAT  = 2;
  localparam int PLEN = 8;
  localparam int D    = LAT + 2;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          src_ready = 1'b0;
  logic [DW-1:0] fifo_q = '0;
  logic          fifo_rdreq;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_sop;
  logic          src_eop;
  logic          pkt_done;

  fifo_stream_reader #(.DWIDTH(DW), .RD_LATENCY(LAT), .PKT_LEN(PLEN)) dut (
    .clk_i(clk), .srst_i(srst), .enable_i(enable),
    .fifo_q_i(fifo_q), .fifo_empty_i(fifo_empty), .fifo_rdreq_o(fifo_rdreq),
    .src_data_o(src_data), .src_valid_o(src_valid), .src_ready_i(src_ready),
    .src_sop_o(src_sop), .src_eop_o(src_eop), .pkt_done_o(pkt_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // FIFO contents, FIFO output pipeline, and words owed to the sink in order.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] pipe1 = '0;
  int outstanding = 0, idx = 0, delivered = 0, reads = 0;
  logic exp_done = 1'b0, stalled_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic prev_sop = 1'b0, prev_eop = 1'b0;

  logic s_rd, s_valid, s_ready, s_sop, s_eop, s_done, s_empty, s_srst, s_hs;
  logic [DW-1:0] s_data;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: sample and check mid-cycle, then advance the FIFO and stream model.
  task automatic tick();
    logic [DW-1:0] w;
    @(negedge clk);
    s_rd = fifo_rdreq; s_valid = src_valid; s_ready = src_ready; s_data = src_data;
    s_sop = src_sop; s_eop = src_eop; s_done = pkt_done; s_empty = fifo_empty; s_srst = srst;
    s_hs = s_valid && s_ready && !s_srst;

    checkOutput("rd_when_empty", 64'(s_rd && s_empty), 64'(0));
    if (!s_srst) checkOutput("outstanding_bound", 64'(outstanding + int'(s_rd) <= D), 64'(1));
    if (stalled_prev) begin
      checkOutput("hold_valid", 64'(s_valid), 64'(1));
      checkOutput("hold_data", 64'(s_data), 64'(prev_data));
      checkOutput("hold_sop", 64'(s_sop), 64'(prev_sop));
      checkOutput("hold_eop", 64'(s_eop), 64'(prev_eop));
    end
    checkOutput("pkt_done", 64'(s_done), 64'(exp_done));
    exp_done = 1'b0;
    if (s_hs) begin
      if (exp_q.size() == 0) begin
        checkOutput("dup_word", 64'(1), 64'(0));
      end else begin
        w = exp_q.pop_front();
        checkOutput("data", 64'(s_data), 64'(w));
      end
      checkOutput("sop", 64'(s_sop), 64'(idx == 0));
      checkOutput("eop", 64'(s_eop), 64'(idx == PLEN - 1));
      exp_done = (idx == PLEN - 1);
      idx = (idx == PLEN - 1) ? 0 : idx + 1;
    end
    stalled_prev = s_valid && !s_ready && !s_srst;
    prev_data = s_data; prev_sop = s_sop; prev_eop = s_eop;

    @(posedge clk);
    #1;
    if (s_srst) begin
      mq.delete(); exp_q.delete();
      idx = 0; outstanding = 0; exp_done = 1'b0; stalled_prev = 1'b0;
    end else begin
      fifo_q = pipe1;
      if (s_rd) begin
        pipe1 = (mq.size() > 0) ? mq.pop_front() : '0;
        exp_q.push_back(pipe1);
        outstanding++;
        reads++;
      end
      if (s_hs) begin
        outstanding--;
        delivered++;
      end
    end
    fifo_empty = (mq.size() == 0);
  endtask

  task automatic applyStimulus(input logic en, input logic rdy, input logic rst);
    enable = en; src_ready = rdy; srst = rst;
    tick();
  endtask

  task automatic reset_dut();
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int run_len, done_cnt, d0, r0, rd_during, pushed;
    logic seen, gap, first;

    // Reset state
    reset_dut();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_valid", 64'(s_valid), 64'(0));
    checkOutput("rst_rdreq", 64'(s_rd), 64'(0));
    checkOutput("rst_sop", 64'(s_sop), 64'(0));
    checkOutput("rst_eop", 64'(s_eop), 64'(0));
    checkOutput("rst_done", 64'(s_done), 64'(0));
    checkOutput("rst_data", 64'(s_data), 64'(0));

    // Single word: rdreq same cycle, valid LAT+1 cycles later
    push_word(16'hA5);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("single_rdreq", 64'(s_rd), 64'(1));
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("single_rdreq_once", 64'(s_rd), 64'(0));
    checkOutput("single_early1", 64'(s_valid), 64'(0));
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("single_early2", 64'(s_valid), 64'(0));
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("single_valid", 64'(s_valid), 64'(1));
    checkOutput("single_data", 64'(s_data), 64'(16'hA5));
    checkOutput("single_sop", 64'(s_sop), 64'(1));
    checkOutput("single_eop", 64'(s_eop), 64'(0));

    // Streaming 64 words at full rate
    reset_dut();
    for (int i = 0; i < 64; i++) push_word(16'(i));
    d0 = delivered; run_len = 0; done_cnt = 0; seen = 0; gap = 0;
    for (int c = 0; c < 120; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (s_done) done_cnt++;
      if (s_valid) begin
        seen = 1;
        if (!gap) run_len++;
      end else if (seen) gap = 1;
    end
    checkOutput("stream_run", 64'(run_len), 64'(64));
    checkOutput("stream_count", 64'(delivered - d0), 64'(64));
    checkOutput("stream_pkt_done", 64'(done_cnt), 64'(8));

    // Random backpressure with random FIFO fill
    reset_dut();
    d0 = delivered; pushed = 0;
    for (int c = 0; c < 1500; c++) begin
      if (pushed < 200 && $urandom_range(0, 1) == 1) begin
        push_word(16'($urandom));
        pushed++;
      end
      applyStimulus(1'b1, $urandom_range(0, 99) < 30, 1'b0);
    end
    for (int c = 0; c < 300; c++) begin
      if (mq.size() == 0 && exp_q.size() == 0) break;
      applyStimulus(1'b1, 1'b1, 1'b0);
    end
    checkOutput("bp_count", 64'(delivered - d0), 64'(pushed));
    checkOutput("bp_leftover", 64'(exp_q.size() + mq.size()), 64'(0));

    // Ready held low: exactly D reads, then full-rate drain
    reset_dut();
    for (int i = 0; i < 10; i++) push_word(16'(16'h200 + i));
    r0 = reads;
    for (int c = 0; c < 20; c++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("hold_reads", 64'(reads - r0), 64'(D));
    checkOutput("hold_rdreq_off", 64'(s_rd), 64'(0));
    d0 = delivered; run_len = 0; seen = 0; gap = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (s_valid) begin
        seen = 1;
        if (!gap) run_len++;
      end else if (seen) gap = 1;
    end
    checkOutput("hold_run", 64'(run_len), 64'(10));
    checkOutput("hold_count", 64'(delivered - d0), 64'(10));

    // Enable low mid-packet
    reset_dut();
    for (int i = 0; i < 8; i++) push_word(16'(i));
    for (int c = 0; c < 6; c++) applyStimulus(1'b1, 1'b0, 1'b0);
    d0 = delivered; rd_during = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (s_rd) rd_during++;
    end
    checkOutput("en_inflight_delivered", 64'(delivered - d0), 64'(D));
    checkOutput("en_no_reads", 64'(rd_during), 64'(0));
    checkOutput("en_stalled", 64'(s_valid), 64'(0));
    first = 1; done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (s_done) done_cnt++;
      if (s_hs && first) begin
        first = 0;
        checkOutput("en_resume_sop", 64'(s_sop), 64'(0));
        checkOutput("en_resume_data", 64'(s_data), 64'(4));
      end
    end
    checkOutput("en_total", 64'(delivered - d0), 64'(8));
    checkOutput("en_pkt_done", 64'(done_cnt), 64'(1));

    // Reset mid-packet
    reset_dut();
    for (int i = 0; i < 8; i++) push_word(16'(16'h10 + i));
    d0 = delivered;
    for (int c = 0; c < 20; c++) begin
      if (delivered - d0 >= 3) break;
      applyStimulus(1'b1, 1'b1, 1'b0);
    end
    checkOutput("mid_reach_word3", 64'(delivered - d0), 64'(3));
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("mid_rst_valid", 64'(s_valid), 64'(0));
    checkOutput("mid_rst_sop", 64'(s_sop), 64'(0));
    checkOutput("mid_rst_eop", 64'(s_eop), 64'(0));
    checkOutput("mid_rst_done", 64'(s_done), 64'(0));
    checkOutput("mid_rst_rdreq", 64'(s_rd), 64'(0));
    checkOutput("mid_rst_data", 64'(s_data), 64'(0));
    for (int i = 0; i < 8; i++) push_word(16'(16'h100 + i));
    first = 1;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      if (s_hs && first) begin
        first = 0;
        checkOutput("mid_next_sop", 64'(s_sop), 64'(1));
        checkOutput("mid_next_data", 64'(s_data), 64'(16'h100));
      end
    end
    checkOutput("mid_next_seen", 64'(first), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
